// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment word monitor.
// Segment buses are written a..g (index 0 = a) and are active-low.
package ssd_pkg;

    localparam int unsigned NUM_DISP = 6;
    localparam int unsigned CHAR_W   = 8;
    localparam int unsigned CNT_W    = 16;

    typedef logic [0:6] seg_t;
    typedef seg_t [NUM_DISP-1:0] seg_word_t;

    localparam seg_t SEG_H       = 7'b1001000;
    localparam seg_t SEG_E       = 7'b0110000;
    localparam seg_t SEG_L       = 7'b1110001;
    localparam seg_t SEG_O       = 7'b0000001;
    localparam seg_t SEG_R       = 7'b1111010;
    localparam seg_t SEG_D       = 7'b1000010;
    localparam seg_t SEG_BLANK   = 7'b1111111;
    localparam seg_t SEG_W_LEFT  = 7'b1100001;
    localparam seg_t SEG_W_RIGHT = 7'b1000011;

    localparam logic [CHAR_W-1:0] ASCII_SPACE   = 8'h20;
    localparam logic [CHAR_W-1:0] ASCII_UNKNOWN = 8'h3F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/ssd_char_decode.sv
// Maps one seven-segment pattern to ASCII; W right half is a continuation
// that appends nothing only when it follows a W left half.
module ssd_char_decode
    import ssd_pkg::*;
(
    input  logic [0:6]        pattern,
    input  logic              prev_was_w_left,
    output logic [CHAR_W-1:0] ascii,
    output logic              append,
    output logic              err
);

    always_comb begin
        ascii  = ASCII_UNKNOWN;
        append = 1'b1;
        err    = 1'b0;
        case (pattern)
            SEG_H:       ascii = 8'h48;
            SEG_E:       ascii = 8'h45;
            SEG_L:       ascii = 8'h4C;
            SEG_O:       ascii = 8'h4F;
            SEG_R:       ascii = 8'h52;
            SEG_D:       ascii = 8'h44;
            SEG_BLANK:   ascii = ASCII_SPACE;
            SEG_W_LEFT:  ascii = 8'h57;
            SEG_W_RIGHT: begin
                if (prev_was_w_left) begin
                    ascii  = 8'h00;
                    append = 1'b0;
                end else begin
                    err = 1'b1;
                end
            end
            default:     err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ssd_word_decoder.sv
// Recovers the word shown on six seven-segment displays once the patterns
// have been stable, and presents it as packed ASCII over valid/ready.
module ssd_word_decoder
    import ssd_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:6]  seg0_in,
    input  logic [0:6]  seg1_in,
    input  logic [0:6]  seg2_in,
    input  logic [0:6]  seg3_in,
    input  logic [0:6]  seg4_in,
    input  logic [0:6]  seg5_in,
    output logic [47:0] word_data,
    output logic [2:0]  word_len,
    output logic        word_err,
    output logic        word_valid,
    input  logic        word_ready
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DISP - 1);

    seg_word_t        seg_now;
    seg_word_t        sample;
    seg_word_t        snapshot;
    seg_word_t        last_emitted;
    logic [CNT_W-1:0] cnt;
    logic             stable_c;
    logic             start_c;
    logic [2:0]       idx;
    logic             prev_w_left;
    state_t           state;
    state_t           state_nxt;
    logic             valid_nxt;

    logic [CHAR_W-1:0] dec_ascii;
    logic              dec_append;
    logic              dec_err;

    assign seg_now  = {seg5_in, seg4_in, seg3_in, seg2_in, seg1_in, seg0_in};
    assign stable_c = (cnt == CNT_W'(STABLE_CYCLES));
    assign start_c  = (state == IDLE) && stable_c && (sample != last_emitted);

    // Sampler and saturating stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= '1;
            cnt    <= '0;
        end else begin
            sample <= seg_now;
            if (seg_now != sample) begin
                cnt <= '0;
            end else if (!stable_c) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_c) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = PRESENT;
            PRESENT: if (word_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valid_nxt = 1'b0;
        if (state_nxt == PRESENT) begin
            valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_valid <= 1'b0;
        end else begin
            word_valid <= valid_nxt;
        end
    end

    ssd_char_decode u_char_decode (
        .pattern         (snapshot[idx]),
        .prev_was_w_left (prev_w_left),
        .ascii           (dec_ascii),
        .append          (dec_append),
        .err             (dec_err)
    );

    // Snapshot capture and per-display pack; only SCAN touches the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot     <= '1;
            last_emitted <= '1;
            word_data    <= '0;
            word_len     <= '0;
            word_err     <= 1'b0;
            idx          <= '0;
            prev_w_left  <= 1'b0;
        end else if (start_c) begin
            snapshot     <= sample;
            last_emitted <= sample;
            word_data    <= '0;
            word_len     <= '0;
            word_err     <= 1'b0;
            idx          <= '0;
            prev_w_left  <= 1'b0;
        end else if (state == SCAN) begin
            if (dec_append) begin
                for (int unsigned b = 0; b < NUM_DISP; b++) begin
                    if (word_len == 3'(b)) begin
                        word_data[b*CHAR_W +: CHAR_W] <= dec_ascii;
                    end
                end
                word_len <= word_len + 3'd1;
            end
            word_err    <= word_err | dec_err;
            prev_w_left <= (snapshot[idx] == SEG_W_LEFT);
            if (idx != LAST_IDX) begin
                idx <= idx + 3'd1;
            end
        end
    end

endmodule

// File: doc/ssd_word_decoder.md
# ssd_word_decoder

Monitor that takes the six active-low seven-segment buses driven by the HELLO/WORLD display logic and recovers the text shown. It waits for the patterns to stay unchanged for a programmable number of cycles, then scans and decodes one display per cycle. It presents the decoded word as packed ASCII over a valid/ready handshake. It sits beside the display driver as an on-chip self-check and feeds the debug/UART path.

## Interface
- STABLE_CYCLES, 16: consecutive unchanged samples required before a word is decoded (1..65535).
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- seg0_in … seg5_in  in  [0:6] each  segment buses for SSD 0..5; index 0 = segment a … 6 = g; 0 = lit.
- word_data  out  48  ASCII word; char 0 in [7:0], char 5 in [47:40]; unused bytes 0x00.
- word_len  out  3  number of valid chars, 0..6.
- word_err  out  1  at least one display decoded as unknown.
- word_valid  out  1  word_data/len/err valid.
- word_ready  in  1  consumer accepts when high with word_valid.

## Operation
- Sample register: captures all six buses every edge (42 bits).
- Stability counter: clears to 0 when the sample differs from the previous sample. Otherwise it increments, saturating at STABLE_CYCLES. "Stable" means counter == STABLE_CYCLES.
- Last-emitted register (42 bits): resets to all-ones (all blank), so an all-blank display never emits.
- FSM states:
  - IDLE:
    - If stable and sample != last-emitted: copy sample to snapshot and to last-emitted, clear pack buffer, len=0, err=0, idx=0, go to SCAN.
  - SCAN:
    - Decode snapshot display idx each cycle; idx 0..5.
    - After idx 5, go to PRESENT.
  - PRESENT:
    - word_valid=1.
    - On word_valid & word_ready, go to IDLE.
- Decode table, with the bus written a..g:
  - 1001000 'H'
  - 0110000 'E'
  - 1110001 'L'
  - 0000001 'O'
  - 1111010 'R'
  - 1000010 'D'
  - 1111111 ' ' (0x20)
  - 1100001 'W' (W left half)
  - 1000011 W right half: continuation, appends nothing, len unchanged.
- Continuation not immediately preceded by a W left half on the previous display: append '?' (0x3F) and set err.
- Any other pattern: append '?' and set err.
- Append writes byte position len, then increments len.
- Scan operates on the snapshot only; input changes during SCAN/PRESENT affect only the sampler and counter.
- New stable word while in PRESENT: held, not dropped. On handshake the FSM returns to IDLE and starts the next scan on the following edge if the condition still holds.
- Intermediate words that come and go during PRESENT are lost; only the current stable word is decoded.

## Timing
- Reset (async assert, sync deassert by the system):
  - word_valid=0, word_data=0, word_len=0, word_err=0.
  - State IDLE, counter 0, sample all-ones, last-emitted all-ones.
- Latency: edge E0 samples a new pattern (counter→0). Counter reaches STABLE_CYCLES at edge E0+STABLE_CYCLES.
  - IDLE→SCAN at E0+STABLE_CYCLES+1.
  - Six SCAN cycles; word_valid rises at edge E0+STABLE_CYCLES+7.
- word_data/len/err are constant while word_valid=1.
- A handshake on the same edge that the input becomes stable is legal; the next scan starts on the following edge.
- Reset mid-SCAN or mid-PRESENT aborts immediately. No partial word is ever presented.

## Structure
- Package ssd_pkg holds:
  - segment pattern constants: SEG_H, SEG_E, SEG_L, SEG_O, SEG_R, SEG_D, SEG_BLANK, SEG_W_LEFT, SEG_W_RIGHT;
  - ASCII constants: space, '?';
  - FSM state enum {IDLE, SCAN, PRESENT}.
- Sub-module ssd_char_decode (combinational):
  - inputs: pattern[0:6], prev_was_w_left;
  - outputs: ascii[7:0], append, err.
  - Instantiated once and shared across scan cycles.

## Test plan
- STABLE_CYCLES=4, reset, then HELLO patterns (H,E,L,L,O,blank) held:
  - word_valid at edge E0+11;
  - word_data = "HELLO " (0x20_4F_4C_4C_45_48), len=6, err=0.
- Switch to WORLD, ready high:
  - word_data = "WORLD" (bytes 57 4F 52 4C 44, byte 5 = 00), len=5, err=0.
- Hold HELLO, pulse one bus to WORLD patterns for 3 cycles, then back:
  - no new word emitted (counter never saturates; pattern equals last-emitted).
- word_ready low for 20 cycles during PRESENT while input changes to WORLD:
  - HELLO word held unchanged;
  - after accept, WORLD word follows 7 edges later.
- SSD 3 driven 0000000, or SSD 1 = W right half after 'H':
  - '?' at the corresponding byte, err=1.
- rst_n asserted during SCAN:
  - outputs zero immediately;
  - after release, the same stable word is decoded and presented fresh.
